// File: rtl/rc6_pkg.sv
// Shared constants, state encoding and size helpers for the RC6-32 key schedule.
package rc6_pkg;

   localparam int          RC6_W = 32;
   localparam logic [31:0] P32   = 32'hB7E15163;
   localparam logic [31:0] Q32   = 32'h9E3779B9;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      INIT,
      MIX,
      DONE
   } ks_state_t;

   // Number of round-key words for r rounds.
   function automatic int rc6_t(input int rounds);
      return 2 * rounds + 4;
   endfunction

   function automatic int rc6_mix_iters(input int c, input int t);
      return 3 * ((c > t) ? c : t);
   endfunction

endpackage

// File: rtl/rc6_key_mix_step.sv
// One combinational A/B mixing iteration of the RC6 key schedule.
module rc6_key_mix_step
   import rc6_pkg::*;
(
   input  logic [RC6_W-1:0] s_i,
   input  logic [RC6_W-1:0] l_j,
   input  logic [RC6_W-1:0] a,
   input  logic [RC6_W-1:0] b,
   output logic [RC6_W-1:0] a_next,
   output logic [RC6_W-1:0] b_next
);

   logic [RC6_W-1:0]   sum_a;
   logic [RC6_W-1:0]   sum_ab;
   logic [RC6_W-1:0]   sum_b;
   logic [2*RC6_W-1:0] rot_dbl;

   always_comb begin
      sum_a   = s_i + a + b;
      a_next  = {sum_a[RC6_W-4:0], sum_a[RC6_W-1:RC6_W-3]};
      sum_ab  = a_next + b;
      sum_b   = l_j + sum_ab;
      // Rotate by shifting a doubled copy; the upper half is the rotated word.
      rot_dbl = {sum_b, sum_b} << sum_ab[4:0];
      b_next  = rot_dbl[2*RC6_W-1:RC6_W];
   end

endmodule

// File: rtl/rc6_key_schedule_ctrl.sv
// RC6-32/r/b key schedule sequencer: key load, S init, 3*max(c,t) mixing, round-key read port.
// Build option RC6_KS_KEYWIPE_EN adds a c-cycle wipe of L before outDone.
module rc6_key_schedule_ctrl
   import rc6_pkg::*;
#(
   parameter int ROUNDS        = 20,
   parameter int MAX_KEY_WORDS = 8
)(
   input  logic        inClk,
   input  logic        inRst_n,
   input  logic        inStart,
   input  logic [3:0]  inKeyLen,
   input  logic [31:0] inKeyWord,
   input  logic        inKeyWordValid,
   input  logic [5:0]  inRkAddr,
   output logic [31:0] outRkData,
   output logic        outBusy,
   output logic        outDone,
   output logic        outKeyReady,
   output logic        outErr
);

   localparam int T  = rc6_t(ROUNDS);
   localparam int IW = $clog2(T);
   localparam int LW = $clog2(MAX_KEY_WORDS);
   localparam int CW = $clog2(rc6_mix_iters(MAX_KEY_WORDS, T));

   ks_state_t         state_reg;
   logic [3:0]        c_reg;
   logic [IW-1:0]     i_reg;
   logic [LW-1:0]     j_reg;
   logic [CW-1:0]     iter_reg;
   logic [RC6_W-1:0]  a_reg;
   logic [RC6_W-1:0]  b_reg;
   logic [RC6_W-1:0]  acc_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              ready_reg;
   logic              err_reg;

   logic [RC6_W-1:0]  s_mem [T];
   logic [RC6_W-1:0]  l_mem [MAX_KEY_WORDS];

   logic [RC6_W-1:0]  a_next;
   logic [RC6_W-1:0]  b_next;
   logic              len_ok;
   logic              i_last;
   logic              j_last;
   logic [CW-1:0]     mix_last;

   logic              s_we;
   logic [IW-1:0]     s_waddr;
   logic [RC6_W-1:0]  s_wdata;
   logic              l_we;
   logic [LW-1:0]     l_waddr;
   logic [RC6_W-1:0]  l_wdata;

   assign len_ok   = (inKeyLen != 4'd0) && (inKeyLen <= 4'(MAX_KEY_WORDS));
   assign i_last   = (i_reg == IW'(T - 1));
   assign j_last   = (4'(j_reg) == c_reg - 4'd1);
   assign mix_last = CW'(rc6_mix_iters(int'(c_reg), T) - 1);

   rc6_key_mix_step u_step (
      .s_i    (s_mem[i_reg]),
      .l_j    (l_mem[j_reg]),
      .a      (a_reg),
      .b      (b_reg),
      .a_next (a_next),
      .b_next (b_next)
   );

   always_ff @(posedge inClk or negedge inRst_n) begin
      if (!inRst_n) begin
         state_reg <= IDLE;
         c_reg     <= '0;
         i_reg     <= '0;
         j_reg     <= '0;
         iter_reg  <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         acc_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         ready_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (inStart) begin
                  if (len_ok) begin
                     c_reg     <= inKeyLen;
                     ready_reg <= 1'b0;
                     busy_reg  <= 1'b1;
                     j_reg     <= '0;
                     state_reg <= LOAD;
                  end else begin
                     err_reg <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (inKeyWordValid) begin
                  if (j_last) begin
                     j_reg     <= '0;
                     i_reg     <= '0;
                     acc_reg   <= P32;
                     state_reg <= INIT;
                  end else begin
                     j_reg <= j_reg + LW'(1);
                  end
               end
            end
            INIT: begin
               acc_reg <= acc_reg + Q32;
               if (i_last) begin
                  i_reg     <= '0;
                  j_reg     <= '0;
                  a_reg     <= '0;
                  b_reg     <= '0;
                  iter_reg  <= '0;
                  state_reg <= MIX;
               end else begin
                  i_reg <= i_reg + IW'(1);
               end
            end
            MIX: begin
               a_reg    <= a_next;
               b_reg    <= b_next;
               i_reg    <= i_last ? '0 : i_reg + IW'(1);
               j_reg    <= j_last ? '0 : j_reg + LW'(1);
               iter_reg <= iter_reg + CW'(1);
               if (iter_reg == mix_last) begin
                  j_reg     <= '0;
                  state_reg <= DONE;
`ifndef RC6_KS_KEYWIPE_EN
                  done_reg  <= 1'b1;
                  ready_reg <= 1'b1;
`endif
               end
            end
            DONE: begin
`ifdef RC6_KS_KEYWIPE_EN
               // Wipe L[0..c-1] first; the completion pulse follows the last wipe.
               if (done_reg) begin
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else if (j_last) begin
                  j_reg     <= '0;
                  done_reg  <= 1'b1;
                  ready_reg <= 1'b1;
               end else begin
                  j_reg <= j_reg + LW'(1);
               end
`else
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
`endif
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_comb begin
      s_we    = 1'b0;
      s_waddr = i_reg;
      s_wdata = acc_reg;
      l_we    = 1'b0;
      l_waddr = j_reg;
      l_wdata = inKeyWord;
      case (state_reg)
         LOAD: l_we = inKeyWordValid;
         INIT: s_we = 1'b1;
         MIX: begin
            s_we    = 1'b1;
            s_wdata = a_next;
            l_we    = 1'b1;
            l_wdata = b_next;
         end
`ifdef RC6_KS_KEYWIPE_EN
         DONE: begin
            l_we    = !done_reg;
            l_wdata = '0;
         end
`endif
         default: ;
      endcase
   end

   // S and L carry no reset; outKeyReady gates every read of S.
   always_ff @(posedge inClk) begin
      if (s_we) s_mem[s_waddr] <= s_wdata;
      if (l_we) l_mem[l_waddr] <= l_wdata;
   end

   assign outRkData   = (ready_reg && (int'(inRkAddr) < T)) ? s_mem[inRkAddr[IW-1:0]] : '0;
   assign outBusy     = busy_reg;
   assign outDone     = done_reg;
   assign outKeyReady = ready_reg;
   assign outErr      = err_reg;

endmodule

// File: doc/rc6_key_schedule_ctrl.md
# rc6_key_schedule_ctrl

Sequencer for the RC6-32/r/b key schedule. It accepts a user key as c 32-bit words and initialises the round-key array S with the P32/Q32 progression. It then drives the A/B mixing step for 3·max(c, t) iterations, where t = 2·ROUNDS+4, and holds the finished round keys for the encrypt/decrypt datapath to read. It sits between the host key-load interface and the round engine.

## Interface
- ROUNDS, 20, number of RC6 rounds r; t = 2·ROUNDS+4 round-key words (44)
- MAX_KEY_WORDS, 8, maximum c (256-bit key)
- inClk  in  1  clock, rising edge
- inRst_n  in  1  asynchronous active-low reset
- inStart  in  1  start pulse, sampled in IDLE only
- inKeyLen  in  4  c, key length in words, latched on inStart
- inKeyWord  in  32  key word, L[0] first, little-endian byte packing
- inKeyWordValid  in  1  key word strobe, LOAD state only
- inRkAddr  in  6  round-key read index 0..t-1
- outRkData  out  32  S[inRkAddr], combinational
- outBusy  out  1  high in LOAD/INIT/MIX/DONE
- outDone  out  1  one-cycle completion pulse
- outKeyReady  out  1  high while S holds a valid schedule
- outErr  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE → LOAD → INIT → MIX → DONE → IDLE.
- IDLE: inStart=1 with 1 ≤ inKeyLen ≤ MAX_KEY_WORDS latches c, clears outKeyReady, and enters LOAD. An out-of-range length pulses outErr and stays in IDLE.
- LOAD: each inKeyWordValid writes L[j] and increments j. After c words, j resets to 0 and the block enters INIT. Gaps are allowed.
- INIT: one word per cycle, with S[0]=0xB7E15163 and S[k]=S[k-1]+0x9E3779B9 (mod 2^32), k=0..t-1. A running accumulator is used, not a multiplier. A, B, i and j are cleared.
- MIX: one iteration per cycle through the step sub-module:
  - A' = (S[i]+A+B) <<< 3, and S[i] ← A'
  - B' = (L[j]+A'+B) <<< ((A'+B)[4:0]), and L[j] ← B'
  - i = (i+1) mod t, and j = (j+1) mod c. Both wrap by compare-and-clear, not by modulo hardware.
  - All sums are mod 2^32.
  - Iteration count is 3·max(c,t), which is 132 for all legal c with ROUNDS=20.
- DONE: outDone=1 for one cycle, outKeyReady←1, then IDLE.
- inStart is ignored while outBusy=1. inKeyWordValid is ignored outside LOAD.
- outRkData reads 0 while outKeyReady=0.
- A new inStart in IDLE invalidates the current schedule immediately (outKeyReady←0).

## Timing
- Reset values:
  - state = IDLE
  - outBusy, outDone, outKeyReady, outErr = 0
  - A, B, i, j and all counters = 0
  - S and L are not reset.
- Start sampled at edge 0. LOAD occupies edges 1..c with back-to-back words.
- INIT takes 44 edges and MIX takes 132 edges.
- outDone is high during the cycle following the last MIX edge. With back-to-back words this is cycle c+177 after start. outKeyReady rises on that same edge.
- Read port has zero latency, with no pipeline.
- Reset mid-operation aborts immediately, and outKeyReady stays 0 until a full schedule completes.

## Configuration
- RC6_KS_KEYWIPE_EN
  - Defined: DONE is extended by a wipe phase of c cycles that zeroes L[0..c-1] before outDone. outDone slips by c cycles.
  - Undefined: L retains the final mixed values and DONE is a single cycle.

## Structure
- Package rc6_pkg:
  - P32, Q32, RC6_W=32
  - the t derivation function
  - state enum ks_state_t {IDLE, LOAD, INIT, MIX, DONE}
- Sub-module rc6_key_mix_step:
  - combinational A'/B' computation
  - inputs S[i], L[j], A, B; outputs A', B'
  - includes the 32-bit data-dependent left rotator
- S (t×32) and L (MAX_KEY_WORDS×32) are flop arrays inside rc6_key_schedule_ctrl.

## Test plan
- Reset mid-MIX, then release → all outputs 0 and state IDLE. outRkData=0 until a fresh schedule completes.
- inKeyLen=0 or 9 with inStart → outErr pulse, outBusy stays 0, and any previous schedule is invalidated only on a legal start.
- Stall LOAD after INIT (debug hold) and read the S array → S[0]=0xB7E15163, S[1]=0x5618CB1C, S[43]=0xB7E15163+43·Q32.
- All-zero 128-bit key (c=4, back-to-back) → outDone at cycle 181 and S[0..43] matching the golden model. Encrypting a zero block with that schedule gives 8FC3A536 56B1F778 C129DF4E 9848A41E.
- 256-bit key 0x0123…EF repeated, with a one-idle-cycle gap between words → exactly 132 MIX cycles, and S matches the golden model.
- inStart held high during MIX, plus stray inKeyWordValid in INIT → both ignored, and the schedule is unchanged. With RC6_KS_KEYWIPE_EN, L reads all-zero after outDone.
